// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch stage: owns the fetch PC, issues word requests to imem,
// buffers returned words with their PCs and hands them to the decoder in order.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          CW       = AW + 1;
    localparam int          SW       = CW + 2;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [31:0]   fetch_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_cnt_r;
    logic [CW-1:0] count_r;
    logic [31:0]   fifo_pc_r   [DEPTH];
    logic [31:0]   fifo_inst_r [DEPTH];
    logic [AW-1:0] fifo_rd_ptr_r;
    logic [AW-1:0] fifo_wr_ptr_r;
    logic [31:0]   tag_pc_r    [DEPTH];
    logic [AW-1:0] tag_rd_ptr_r;
    logic [AW-1:0] tag_wr_ptr_r;

    logic          pop_s;
    logic          gnt_fire_s;
    logic          live_rsp_s;
    logic          stale_rsp_s;
    logic          room_s;
    logic          unused_s;
    logic [SW-1:0] occupancy_s;

    // Request throttle, response classification and decoder-facing outputs.
    always_comb begin
        inst_valid  = (count_r != {CW{1'b0}});
        pop_s       = inst_valid & inst_ready;
        // A pop this cycle frees a FIFO slot, which keeps one-per-cycle streaming alive.
        occupancy_s = SW'(outstanding_r) + SW'(drop_cnt_r) + SW'(count_r) - SW'(pop_s);
        room_s      = (occupancy_s < SW'(DEPTH));
        imem_req    = reset & ~redirect & room_s;
        imem_addr   = fetch_pc_r;
        gnt_fire_s  = imem_req & imem_gnt;
        live_rsp_s  = imem_rvalid & ~redirect & (drop_cnt_r == {CW{1'b0}});
        stale_rsp_s = imem_rvalid & ~redirect & (drop_cnt_r != {CW{1'b0}});
        inst_pc     = fifo_pc_r[fifo_rd_ptr_r];
        if (inst_valid) begin
            inst = fifo_inst_r[fifo_rd_ptr_r];
        end else begin
            inst = NOP_INST;
        end
        unused_s    = ^redirect_pc[1:0];
    end

    // Fetch PC, bus accounting counters and queue pointers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
            count_r       <= {CW{1'b0}};
            fifo_rd_ptr_r <= {AW{1'b0}};
            fifo_wr_ptr_r <= {AW{1'b0}};
            tag_rd_ptr_r  <= {AW{1'b0}};
            tag_wr_ptr_r  <= {AW{1'b0}};
        end else if (redirect) begin
            // Every request still on the bus becomes stale; its response is dropped later.
            fetch_pc_r    <= {redirect_pc[31:2], 2'b00};
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= drop_cnt_r + outstanding_r - CW'(imem_rvalid);
            count_r       <= {CW{1'b0}};
            fifo_rd_ptr_r <= {AW{1'b0}};
            fifo_wr_ptr_r <= {AW{1'b0}};
            tag_rd_ptr_r  <= {AW{1'b0}};
            tag_wr_ptr_r  <= {AW{1'b0}};
        end else begin
            if (gnt_fire_s) begin
                fetch_pc_r   <= fetch_pc_r + 32'd4;
                tag_wr_ptr_r <= tag_wr_ptr_r + AW'(1'b1);
            end
            if (live_rsp_s) begin
                tag_rd_ptr_r  <= tag_rd_ptr_r + AW'(1'b1);
                fifo_wr_ptr_r <= fifo_wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                fifo_rd_ptr_r <= fifo_rd_ptr_r + AW'(1'b1);
            end
            if (stale_rsp_s) begin
                drop_cnt_r <= drop_cnt_r - CW'(1'b1);
            end
            outstanding_r <= outstanding_r + CW'(gnt_fire_s) - CW'(live_rsp_s);
            count_r       <= count_r + CW'(live_rsp_s) - CW'(pop_s);
        end
    end

    // PC tag queue and instruction FIFO storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i] <= RESET_PC;
            end
        end else begin
            if (gnt_fire_s) begin
                tag_pc_r[tag_wr_ptr_r] <= fetch_pc_r;
            end
            if (live_rsp_s) begin
                fifo_pc_r[fifo_wr_ptr_r]   <= tag_pc_r[tag_rd_ptr_r];
                fifo_inst_r[fifo_wr_ptr_r] <= imem_rdata;
            end
        end
    end
endmodule
